// File: rtl/mdu.sv
// Multiply/divide unit: executes MULT/MULTU/DIV/DIVU over a fixed number of cycles into HI/LO,
// and serves MTHI/MTLO writes and MFHI/MFLO reads.
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  MDUOp,
    input  logic        start,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDUResult
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MFHI  = 4'd5,
        MDU_MFLO  = 4'd6,
        MDU_MTHI  = 4'd7,
        MDU_MTLO  = 4'd8
    } mdu_op_e;

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [31:0]        hi_q, lo_q;
    logic [31:0]        hi_pend_q, lo_pend_q;
    logic               wr_pend_q;

    logic [31:0]        hi_pend_d, lo_pend_d;
    logic               wr_pend_d;
    logic [CNT_W-1:0]   cnt_d;
    logic               long_op;

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic signed [31:0] dvd_s, dvs_s, quot_s, rem_s;
    logic        [31:0] dvs_u, quot_u, rem_u;
    logic               div_ovf;

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path infers a latch.
        hi_pend_d = '0;
        lo_pend_d = '0;
        wr_pend_d = 1'b1;
        cnt_d     = '0;
        long_op   = 1'b0;

        prod_s  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        prod_u  = {32'd0, a} * {32'd0, b};

        // The divisor is forced non-zero so the datapath never produces X; the result is discarded anyway.
        dvd_s   = $signed(a);
        dvs_s   = (b == 32'd0) ? 32'sd1 : $signed(b);
        dvs_u   = (b == 32'd0) ? 32'd1 : b;
        div_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        quot_s  = div_ovf ? $signed(32'h8000_0000) : dvd_s / dvs_s;
        rem_s   = div_ovf ? 32'sd0 : dvd_s % dvs_s;
        quot_u  = a / dvs_u;
        rem_u   = a % dvs_u;

        case (MDUOp)
            MDU_MULT: begin
                long_op   = 1'b1;
                cnt_d     = CNT_W'(MULT_CYCLES);
                {hi_pend_d, lo_pend_d} = prod_s;
            end
            MDU_MULTU: begin
                long_op   = 1'b1;
                cnt_d     = CNT_W'(MULT_CYCLES);
                {hi_pend_d, lo_pend_d} = prod_u;
            end
            MDU_DIV: begin
                long_op   = 1'b1;
                cnt_d     = CNT_W'(DIV_CYCLES);
                hi_pend_d = rem_s;
                lo_pend_d = quot_s;
                wr_pend_d = (b != 32'd0);
            end
            MDU_DIVU: begin
                long_op   = 1'b1;
                cnt_d     = CNT_W'(DIV_CYCLES);
                hi_pend_d = rem_u;
                lo_pend_d = quot_u;
                wr_pend_d = (b != 32'd0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            hi_pend_q <= '0;
            lo_pend_q <= '0;
            wr_pend_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            case (state_q)
                IDLE: begin
                    if (start && long_op) begin
                        state_q   <= BUSY;
                        cnt_q     <= cnt_d;
                        hi_pend_q <= hi_pend_d;
                        lo_pend_q <= lo_pend_d;
                        wr_pend_q <= wr_pend_d;
                    end else if (MDUOp == MDU_MTHI) begin
                        hi_q <= a;
                    end else if (MDUOp == MDU_MTLO) begin
                        lo_q <= a;
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= IDLE;
                        if (wr_pend_q) begin
                            hi_q <= hi_pend_q;
                            lo_q <= lo_pend_q;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        case (MDUOp)
            MDU_MFHI: MDUResult = hi_q;
            MDU_MFLO: MDUResult = lo_q;
            default:  MDUResult = '0;
        endcase
    end

    assign busy = (state_q == BUSY);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: stimulus pushes expected HI/LO and busy length, a monitor pops on busy fall.
module tb_mdu;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [3:0]  MDUOp = '0;
    logic        start = 1'b0;
    logic        busy;
    logic [31:0] HI, LO, MDUResult;

    mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset_n(reset_n), .a(a), .b(b), .MDUOp(MDUOp), .start(start),
        .busy(busy), .HI(HI), .LO(LO), .MDUResult(MDUResult)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          len;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic on 64-bit integers; returns {HI, LO}. Divisor is non-zero here.
    function automatic logic [63:0] ref_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        longint          sx, sy, q, r;
        longint unsigned ux, uy, p;
        sx = $signed(x);
        sy = $signed(y);
        ux = {32'd0, x};
        uy = {32'd0, y};
        case (op)
            4'd1: begin q = sx * sy; return q; end
            4'd2: begin p = ux * uy; return p; end
            4'd3: begin q = sx / sy; r = sx % sy; return {r[31:0], q[31:0]}; end
            4'd4: return {x % y, x / y};
            default: return 64'd0;
        endcase
    endfunction

    task automatic issue(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y, input logic st);
        logic        long_op;
        logic [63:0] r;
        logic [31:0] exp_res;
        long_op = st && (op >= 4'd1) && (op <= 4'd4);
        exp_res = (op == 4'd5) ? m_hi : (op == 4'd6) ? m_lo : 32'd0;
        MDUOp = op;
        a     = x;
        b     = y;
        start = st;
        #1;
        check("MDUResult", {32'd0, MDUResult}, {32'd0, exp_res});
        if (long_op) begin
            check("busy_at_start", {63'd0, busy}, 64'd0);
            if ((op == 4'd3 || op == 4'd4) && y == 32'd0) r = {m_hi, m_lo};
            else r = ref_op(op, x, y);
            sb.push_back('{r[63:32], r[31:0], (op <= 4'd2) ? MC : DC});
            m_hi = r[63:32];
            m_lo = r[31:0];
        end else if (op == 4'd7) begin
            m_hi = x;
        end else if (op == 4'd8) begin
            m_lo = x;
        end
        @(negedge clk);
        MDUOp = '0;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        if (!long_op) begin
            check("HI_after_op", {32'd0, HI}, {32'd0, m_hi});
            check("LO_after_op", {32'd0, LO}, {32'd0, m_lo});
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 64) begin
            @(negedge clk);
            n++;
        end
        check("busy_timeout", {63'd0, busy}, 64'd0);
    endtask

    // Monitor: counts busy cycles and compares HI/LO when busy falls.
    initial begin
        int   bcnt;
        exp_t e;
        bcnt = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                bcnt = 0;
            end else if (busy) begin
                bcnt++;
            end else if (bcnt != 0) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected: busy fell after %0d cycles with nothing expected", bcnt);
                end else begin
                    e = sb.pop_front();
                    check("busy_len", 64'(bcnt), 64'(e.len));
                    check("HI_commit", {32'd0, HI}, {32'd0, e.hi});
                    check("LO_commit", {32'd0, LO}, {32'd0, e.lo});
                end
                bcnt = 0;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        MDUOp = 4'd5;
        #3;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_HI", {32'd0, HI}, 64'd0);
        check("rst_LO", {32'd0, LO}, 64'd0);
        check("rst_MDUResult", {32'd0, MDUResult}, 64'd0);
        MDUOp = 4'd0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        issue(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b1); wait_idle();
        issue(4'd2, 32'hFFFF_FFFE, 32'd3, 1'b1); wait_idle();
        issue(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b1); wait_idle();
        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1); wait_idle();

        issue(4'd7, 32'h1234, 32'd0, 1'b0);
        issue(4'd8, 32'h5678, 32'd0, 1'b0);
        issue(4'd5, 32'd0, 32'd0, 1'b0);
        issue(4'd6, 32'd0, 32'd0, 1'b0);

        issue(4'd4, 32'd7, 32'd0, 1'b1);
        @(negedge clk);
        MDUOp = 4'd1;
        start = 1'b1;
        a     = 32'd6;
        b     = 32'd7;
        @(negedge clk);
        MDUOp = 4'd0;
        start = 1'b0;
        wait_idle();

        issue(4'd3, 32'd100, 32'd7, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_HI", {32'd0, HI}, 64'd0);
        check("midrst_LO", {32'd0, LO}, 64'd0);
        sb.delete();
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        issue(4'd6, 32'd0, 32'd0, 1'b0);
        issue(4'd1, 32'd6, 32'd7, 1'b1); wait_idle();

        for (int i = 0; i < 80; i++) begin
            logic [3:0]  op;
            logic [31:0] x, y;
            logic        st;
            op = 4'($urandom_range(0, 15));
            st = ($urandom_range(0, 3) != 0);
            x  = ($urandom_range(0, 4) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 5))
                0:       y = 32'd0;
                1:       y = 32'hFFFF_FFFF;
                2:       y = $urandom_range(1, 9);
                default: y = $urandom;
            endcase
            issue(op, x, y, st);
            if (busy) wait_idle();
        end

        repeat (3) @(negedge clk);
        check("sb_drain", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
